// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-activation threshold stage.
`ifndef OUTPUT_DIM
`define OUTPUT_DIM 4
`endif
`ifndef BIT_CNT
`define BIT_CNT 8
`endif

package bnn_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } stage_state_e;

  localparam int VEC_CNT_W = 32;
  localparam int THR_W     = `BIT_CNT;

  typedef logic signed [THR_W-1:0] thr_word_t;

endpackage

// File: rtl/thresh_regfile.sv
// Per-channel threshold register file with loaded mask and all-loaded lookahead.
// Define BIN_ACT_FLIP_EN to add a per-channel comparison flip bit.
module thresh_regfile
  import bnn_pkg::*;
#(
  parameter int  PARAM_CH  = 4,
  parameter int  PARAM_BIT = 8,
  localparam int AW        = (PARAM_CH > 1) ? $clog2(PARAM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [AW-1:0]                      addr,
  input  logic [PARAM_BIT-1:0]               data,
`ifdef BIN_ACT_FLIP_EN
  input  logic                               flip,
  output logic [PARAM_CH-1:0]                flip_q,
`endif
  input  logic                               clr,
  output logic [PARAM_CH-1:0][PARAM_BIT-1:0] thr_q,
  output logic                               all_loaded_d
);

  logic [PARAM_CH-1:0] mask_q;
  logic [PARAM_CH-1:0] mask_d;
  logic                addr_ok;
  logic                wr_en;

  assign addr_ok = (int'(addr) < PARAM_CH);
  // A clear in the same cycle discards the write.
  assign wr_en   = we && !clr && addr_ok;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mask_d = mask_q;
    if (clr) begin
      mask_d = '0;
    end else if (wr_en) begin
      mask_d[addr] = 1'b1;
    end
  end

  // Lookahead lets the FSM enter RUN on the same edge that completes the mask.
  assign all_loaded_d = &mask_d;

  // NOTE: sequential state uses non-blocking assignments only; the threshold
  // array is small and its reset value is observable, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      thr_q  <= '0;
    end else begin
      mask_q <= mask_d;
      if (wr_en) begin
        thr_q[addr] <= data;
      end
    end
  end

`ifdef BIN_ACT_FLIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_q <= '0;
    end else if (wr_en) begin
      flip_q[addr] <= flip;
    end
  end
`endif

endmodule

// File: rtl/bin_act_threshold_stage.sv
// Binary activation stage: signed threshold compare, two-deep valid/ready pipeline, vector counter.
// Define BIN_ACT_FLIP_EN to add the thr_flip port for per-channel comparison inversion.
`ifndef OUTPUT_DIM
`define OUTPUT_DIM 4
`endif
`ifndef BIT_CNT
`define BIT_CNT 8
`endif

module bin_act_threshold_stage
  import bnn_pkg::*;
#(
  parameter int  PARAM_CH  = `OUTPUT_DIM,
  parameter int  PARAM_BIT = `BIT_CNT,
  localparam int AW        = (PARAM_CH > 1) ? $clog2(PARAM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PARAM_CH-1:0][PARAM_BIT-1:0] value_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [PARAM_CH-1:0]                act_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  input  logic                               thr_we,
  input  logic [AW-1:0]                      thr_addr,
  input  logic [PARAM_BIT-1:0]               thr_data,
`ifdef BIN_ACT_FLIP_EN
  input  logic                               thr_flip,
`endif
  input  logic                               thr_clr,
  output logic                               loaded_o,
  output logic [VEC_CNT_W-1:0]               vec_cnt_o
);

  logic [PARAM_CH-1:0][PARAM_BIT-1:0] thr_q;
  logic                               all_loaded_d;
  logic [PARAM_CH-1:0]                cmp;
  stage_state_e                       state_q;
  stage_state_e                       state_d;
  logic                               s1_valid;
  logic [PARAM_CH-1:0]                s1_act;
  logic                               s2_valid;
  logic [PARAM_CH-1:0]                s2_act;
  logic                               s2_free;
  logic                               accept;
  logic [VEC_CNT_W-1:0]               cnt_q;
`ifdef BIN_ACT_FLIP_EN
  logic [PARAM_CH-1:0]                flip_q;
`endif

  thresh_regfile #(
    .PARAM_CH  (PARAM_CH),
    .PARAM_BIT (PARAM_BIT)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .we           (thr_we),
    .addr         (thr_addr),
    .data         (thr_data),
`ifdef BIN_ACT_FLIP_EN
    .flip         (thr_flip),
    .flip_q       (flip_q),
`endif
    .clr          (thr_clr),
    .thr_q        (thr_q),
    .all_loaded_d (all_loaded_d)
  );

  // Compare uses the registered thresholds, so a same-cycle write only affects later vectors.
  always_comb begin
    cmp = '0;
    for (int c = 0; c < PARAM_CH; c++) begin
      cmp[c] = ($signed(value_i[c]) >= $signed(thr_q[c]));
`ifdef BIN_ACT_FLIP_EN
      if (flip_q[c]) begin
        cmp[c] = ($signed(value_i[c]) <= $signed(thr_q[c]));
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    unique case (state_q)
      LOAD: if (all_loaded_d) state_d = RUN;
      RUN: begin
        ready_o = ~s1_valid | ~s2_valid | ready_i;
        if (thr_clr) state_d = LOAD;
      end
    endcase
  end

  assign s2_free = ~s2_valid | ready_i;
  assign accept  = valid_i & ready_o;

  // The pipeline drains regardless of FSM state so in-flight vectors survive a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_act   <= '0;
      s2_valid <= 1'b0;
      s2_act   <= '0;
    end else begin
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_act <= s1_act;
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_act   <= cmp;
      end else if (s2_free) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (s2_valid && ready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign act_o     = s2_act;
  assign valid_o   = s2_valid;
  assign loaded_o  = (state_q == RUN);
  assign vec_cnt_o = cnt_q;

endmodule

// File: doc/bin_act_threshold_stage.md
# bin_act_threshold_stage

Downstream stage of the fixed-input / binary-weight layer: consumes one vector of `OUTPUT_DIM` signed `BIT_CNT`-bit accumulator results per handshake and emits one `OUTPUT_DIM`-bit binary activation vector for the next binary layer. The block holds a per-channel threshold register file that implements folded batch-norm plus sign. It also provides a two-deep valid/ready pipeline with full backpressure, and counts delivered vectors.

## Interface
- PARAM_CH, default `OUTPUT_DIM: channel count, the width of the input vector.
- PARAM_BIT, default `BIT_CNT: bit width of each signed two's-complement value and threshold.
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- value_i, input, [PARAM_CH-1:0][PARAM_BIT-1:0]: accumulator results, signed.
- valid_i, input, 1: value_i valid.
- ready_o, output, 1: stage accepts value_i this cycle.
- act_o, output, [PARAM_CH-1:0]: binary activations; 1 means +1, 0 means -1.
- valid_o, output, 1: act_o valid.
- ready_i, input, 1: downstream accepts act_o.
- thr_we, input, 1: threshold write strobe.
- thr_addr, input, $clog2(PARAM_CH): channel to write. If PARAM_CH is 1, the width is 1.
- thr_data, input, PARAM_BIT: signed threshold.
- thr_flip, input, 1: per-channel comparison inversion. This port exists only when the macro is defined.
- thr_clr, input, 1: invalidate all thresholds.
- loaded_o, output, 1: all thresholds written (state RUN).
- vec_cnt_o, output, 32: count of output handshakes.

## Operation
- The FSM has two states.
  - LOAD is the reset state. ready_o is 0 in LOAD.
  - RUN: ready_o is driven by the pipeline rule.
- A loaded_mask[PARAM_CH] register is set bit-wise on thr_we.
  - LOAD→RUN at the clock edge where the mask becomes all-ones, including through the write in that cycle.
  - thr_clr in any state clears the mask and moves to LOAD the next cycle.
  - If thr_we and thr_clr occur in the same cycle, thr_clr wins and the write is discarded.
  - thr_addr ≥ PARAM_CH is ignored.
- Comparison is signed, full PARAM_BIT width, with no extension needed: act[c] = (value_i[c] >= thr[c]).
- Thresholds are sampled in the acceptance cycle. A thr_we in the same cycle as acceptance affects only later vectors.
- Thresholds may be rewritten in RUN; the block stays in RUN.
- In-flight vectors always drain, including after thr_clr.
- Pipeline:
  - Stage S1 registers the compare result.
  - Stage S2 is the output register.
  - S2 loads from S1 when S2 is empty or ready_i=1.
  - S1 loads when state=RUN and (S1 is empty or S1 advances).
  - ready_o = (state==RUN) & (~s1_valid | ~s2_valid | ready_i).
  - This rule gives one vector per cycle sustained with no bubbles.
- vec_cnt_o increments on valid_o & ready_i and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values:
  - act_o=0, valid_o=0, ready_o=0, loaded_o=0, vec_cnt_o=0.
  - Thresholds=0, mask=0, state=LOAD.
  - Flip bits=0 when compiled in.
- Latency: acceptance at edge N gives valid_o high after edge N+1, with no stall.
- Throughput: 1 vector/cycle.
- Handshake:
  - While valid_o=1 and ready_i=0, act_o and valid_o hold stable.
  - valid_o never depends combinationally on ready_i.
- Full condition: S1 and S2 both valid and ready_i=0 gives ready_o=0.
- Simultaneous events: an S2 drain and an S1 refill in the same cycle are legal and do not lose data.
- Reset mid-operation: pipeline contents are discarded immediately, and the block returns to LOAD.
- loaded_o is registered and equals (state==RUN).

## Configuration
- `BIN_ACT_FLIP_EN`
  - Defined: the thr_flip port and a per-channel flip register are present. This supports negative batch-norm gamma. act[c] = flip[c] ? (value_i[c] <= thr[c]) : (value_i[c] >= thr[c]).
  - Undefined: no port and no register; the comparison is always >=.

## Structure
- Package bnn_pkg holds:
  - the state enum (LOAD, RUN),
  - the VEC_CNT_W=32 constant,
  - the typedef for a signed PARAM_BIT threshold word.
- Sub-module thresh_regfile holds thresholds, flip bits and loaded_mask. It has a write port and outputs the all-loaded flag.
- The top level holds the FSM, compare, pipeline and counter.

## Test plan
All scenarios use PARAM_CH=4 and PARAM_BIT=8.
- Reset, write thresholds to channels 0,1,2 only → loaded_o=0 and ready_o=0. Write channel 3 → loaded_o=1 on the next cycle.
- thr={0,-5,10,127}, value_i={0,-6,10,-128} → act_o=4'b0101 (bit0 = channel 0) two cycles after acceptance.
- Stream 8 vectors back-to-back with ready_i=1 → 8 consecutive valid_o cycles, vec_cnt_o=8.
- Hold ready_i=0 for 5 cycles during a stream → ready_o drops after 2 accepted vectors. act_o stays stable. On release, no vectors are lost or duplicated.
- Assert thr_clr with 2 vectors in flight → both vectors are delivered, ready_o=0, and loaded_o=0 the next cycle.
- With `BIN_ACT_FLIP_EN`: flip[1]=1, thr[1]=3, value 3 → act[1]=1; value 4 → act[1]=0.
